// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end: instruction width, fetch FSM
// encoding, default address width and the NOP used to fill a flushed slot.
package rv32i_pkg;

    localparam int                 INSTR_W       = 32;
    localparam int                 ADDR_W_DEF    = 10;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment.
// Without load or increment, the register holds its value.
module fetch_pc_reg #(
    parameter int               ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Increment wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (incr_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues word fetches, and holds one
// instruction for decode. It handles redirects and stalls, and traps misaligned targets.
module fetch_sequencer
    import rv32i_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               misalign_err
);

    fetch_state_e       state_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               err_q;
    logic [ADDR_W-1:0]  pc;

    logic redir_act;
    logic redir_aligned;
    logic fetch_fire;

    // A redirect outranks a fetch landing in the same cycle, so that word is dropped.
    assign redir_act     = redirect_valid && (state_q != ST_ERROR);
    assign redir_aligned = is_word_aligned(redirect_target[1:0]);
    assign fetch_fire    = (state_q == ST_FETCH) && !stall && imem_ready;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (redir_act && redir_aligned),
        .load_val_i (redirect_target),
        .incr_i     (fetch_fire && !redir_act),
        .pc_o       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            err_q         <= 1'b0;
        end else if (redir_act) begin
            instr_valid_q <= 1'b0;
            if (redir_aligned) begin
                state_q <= ST_FETCH;
                instr_q <= NOP_INSTR;
            end else begin
                state_q <= ST_ERROR;
                err_q   <= 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (fetch_fire) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall && instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_ERROR: begin
                    instr_valid_q <= 1'b0;
                    err_q         <= 1'b1;
                end
                default: state_q <= ST_ERROR;
            endcase
        end
    end

    assign imem_req     = (state_q == ST_FETCH) && !stall;
    assign imem_addr    = pc;
    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, steady fetch, hold, redirects,
// stall, PC wrap, mid-HOLD reset and misaligned-redirect trap.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [9:0]  redirect_target;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_ready;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   32'(imem_req),     32'd0);
        check({tag, "_addr"},  32'(imem_addr),    32'h000);
        check({tag, "_vld"},   32'(instr_valid),  32'd0);
        check({tag, "_instr"}, instr,             NOP);
        check({tag, "_ipc"},   32'(instr_pc),     32'h000);
        check({tag, "_err"},   32'(misalign_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        imem_ready = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        tick(); tick();
        check_reset_state("rst");

        // Steady fetch from reset: fetches at 0x000, 0x004, 0x008, every other cycle.
        reset = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("seq_req",  32'(imem_req),  32'd1);
            check("seq_addr", 32'(imem_addr), 32'(4 * i));
            imem_rdata = 32'hA000_0000 + 32'(i);
            tick();
            check("seq_vld",   32'(instr_valid), 32'd1);
            check("seq_instr", instr,            32'hA000_0000 + 32'(i));
            check("seq_ipc",   32'(instr_pc),    32'(4 * i));
            check("seq_hreq",  32'(imem_req),    32'd0);
            if (i == 2) instr_ready = 1'b0;
            tick();
        end

        // The loop's final tick left the slot undelivered; it must stay put.
        for (int i = 0; i < 5; i++) begin
            check("hold_vld",   32'(instr_valid), 32'd1);
            check("hold_instr", instr,            32'hA000_0002);
            check("hold_ipc",   32'(instr_pc),    32'h008);
            check("hold_req",   32'(imem_req),    32'd0);
            if (i < 4) tick();
        end

        // Aligned redirect during HOLD flushes the slot.
        redirect_valid = 1'b1; redirect_target = 10'h120;
        tick();
        check("rd_vld",   32'(instr_valid), 32'd0);
        check("rd_instr", instr,            NOP);
        check("rd_addr",  32'(imem_addr),   32'h120);
        check("rd_req",   32'(imem_req),    32'd1);
        redirect_valid = 1'b0; imem_rdata = 32'hD00D_0120;
        tick();
        check("rd_cvld",   32'(instr_valid), 32'd1);
        check("rd_cipc",   32'(instr_pc),    32'h120);
        check("rd_cinstr", instr,            32'hD00D_0120);

        // Stall in HOLD ignores instr_ready.
        stall = 1'b1; instr_ready = 1'b1;
        tick();
        check("sth_vld", 32'(instr_valid), 32'd1);
        stall = 1'b0;
        tick();
        check("st_fvld",  32'(instr_valid), 32'd0);
        check("st_faddr", 32'(imem_addr),   32'h124);
        instr_ready = 1'b0; stall = 1'b1; imem_rdata = 32'hBEEF_0124;
        #1;
        check("stf_req", 32'(imem_req), 32'd0);
        tick(); tick();
        check("stf_vld",  32'(instr_valid), 32'd0);
        check("stf_addr", 32'(imem_addr),   32'h124);
        stall = 1'b0;
        tick();
        check("stf_cvld", 32'(instr_valid), 32'd1);
        check("stf_cipc", 32'(instr_pc),    32'h124);

        // Wrap from 0x3FC to 0x000.
        redirect_valid = 1'b1; redirect_target = 10'h3FC;
        tick();
        check("wr_addr", 32'(imem_addr), 32'h3FC);
        redirect_valid = 1'b0; imem_rdata = 32'hCAFE_03FC;
        tick();
        check("wr_ipc",  32'(instr_pc),  32'h3FC);
        check("wr_addr2", 32'(imem_addr), 32'h000);

        // Reset mid-HOLD.
        reset = 1'b1;
        tick();
        check_reset_state("mrst");

        // Redirect in the same cycle as a landing fetch discards the fetch.
        reset = 1'b0;
        tick();
        check("dc_req", 32'(imem_req), 32'd1);
        redirect_valid = 1'b1; redirect_target = 10'h040; imem_rdata = 32'h1111_1111;
        tick();
        check("dc_vld",  32'(instr_valid), 32'd0);
        check("dc_addr", 32'(imem_addr),   32'h040);
        redirect_valid = 1'b0; imem_rdata = 32'h2222_0040;
        tick();
        check("dc_ipc",   32'(instr_pc), 32'h040);
        check("dc_instr", instr,         32'h2222_0040);

        // Misaligned redirect traps; sticky until reset, aligned redirect ignored.
        redirect_valid = 1'b1; redirect_target = 10'h122;
        tick();
        check("ma_err",  32'(misalign_err), 32'd1);
        check("ma_req",  32'(imem_req),     32'd0);
        check("ma_vld",  32'(instr_valid),  32'd0);
        check("ma_addr", 32'(imem_addr),    32'h044);
        redirect_target = 10'h100;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        check("ma_serr",  32'(misalign_err), 32'd1);
        check("ma_sreq",  32'(imem_req),     32'd0);
        check("ma_saddr", 32'(imem_addr),    32'h044);
        reset = 1'b1;
        tick();
        check_reset_state("erst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
